text_console_core: RTL and testbench

Parametrised text-mode display core: a COLS×ROWS character buffer, a cursor that a command port moves and writes, cursor blink, and a per-pixel font lookup pipeline that produces registered RGB. It sits between the VGA sync unit and the top-level RGB pins, replacing a fixed-size text generator plus output buffer. It adds run-time editing commands, a hardware clear sweep and a configurable colour depth. The font ROM stays external and is driven through a one-clock-latency address/data port.

---
 rtl/text_console_core.sv | 201 ++++++++++++++++++++
 tb/tb_text_console_core.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/text_console_core.sv
// Text-mode console: COLS x ROWS character RAM edited by a small command FSM,
// with blinking cursor and a two-stage p_tick pipeline into an external font ROM.
module text_console_core #(
  parameter int                  COLS         = 80,
  parameter int                  ROWS         = 30,
  parameter int                  CHAR_W       = 8,
  parameter int                  CHAR_H       = 16,
  parameter int                  RGB_W        = 3,
  parameter logic [RGB_W-1:0]    FG_COLOR     = '1,
  parameter logic [RGB_W-1:0]    BG_COLOR     = '0,
  parameter int                  BLINK_FRAMES = 30,
  localparam int                 COL_W        = $clog2(COLS),
  localparam int                 ROW_W        = $clog2(ROWS),
  localparam int                 GX_W         = $clog2(CHAR_W),
  localparam int                 GY_W         = $clog2(CHAR_H)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   p_tick,
  input  logic                   video_on,
  input  logic [9:0]             pixel_x,
  input  logic [9:0]             pixel_y,
  input  logic                   cmd_valid,
  input  logic [1:0]             cmd_op,
  input  logic [6:0]             cmd_data,
  output logic                   cmd_ready,
  output logic [6+GY_W:0]        font_addr,
  input  logic [CHAR_W-1:0]      font_data,
  output logic [COL_W-1:0]       cursor_col,
  output logic [ROW_W-1:0]       cursor_row,
  output logic [RGB_W-1:0]       rgb
);

  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = $clog2(CELLS);
  localparam int FC_W   = $clog2(BLINK_FRAMES + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  localparam logic [1:0] OP_WRITE   = 2'd0;
  localparam logic [1:0] OP_LEFT    = 2'd1;
  localparam logic [1:0] OP_NEWLINE = 2'd2;

  logic [6:0]        mem [CELLS];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              we;
  logic [ADDR_W-1:0] waddr, cur_addr;
  logic [6:0]        wdata;

  assign cur_addr   = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
  assign cmd_ready  = (state_q == S_IDLE);
  assign cursor_col = col_q;
  assign cursor_row = row_q;

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    col_d   = col_q;
    row_d   = row_q;
    we      = 1'b0;
    waddr   = cur_addr;
    wdata   = cmd_data;
    if (state_q == S_IDLE) begin
      if (cmd_valid) begin
        case (cmd_op)
          OP_WRITE: begin
            we = 1'b1;
            if (col_q == COL_W'(COLS-1)) begin
              col_d = '0;
              row_d = (row_q == ROW_W'(ROWS-1)) ? '0 : row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
          OP_LEFT: begin
            if (col_q != '0) begin
              col_d = col_q - 1'b1;
            end else if (row_q != '0) begin
              col_d = COL_W'(COLS-1);
              row_d = row_q - 1'b1;
            end
          end
          OP_NEWLINE: begin
            col_d = '0;
            row_d = (row_q == ROW_W'(ROWS-1)) ? '0 : row_q + 1'b1;
          end
          default: begin
            state_d = S_CLEAR;
            clr_d   = '0;
          end
        endcase
      end
    end else begin
      // Sweep one cell per clock with spaces; commands are not accepted meanwhile.
      we    = 1'b1;
      waddr = clr_q;
      wdata = 7'h20;
      if (clr_q == ADDR_W'(CELLS-1)) begin
        state_d = S_IDLE;
        clr_d   = '0;
        col_d   = '0;
        row_d   = '0;
      end else begin
        clr_d = clr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  logic [9:0]        px_col, px_row;
  logic              in_area, hit, frame_tick, pix_on;
  logic [ADDR_W-1:0] rd_addr;
  logic [6:0]        chr_q, chr_d;
  logic [GY_W-1:0]   gy_q, gy_d;
  logic [GX_W-1:0]   gx_q, gx_d;
  logic              von_q, von_d, area_q, area_d, hit_q, hit_d;
  logic [RGB_W-1:0]  rgb_q, rgb_d;
  logic [FC_W-1:0]   frame_q, frame_d;
  logic              blink_q, blink_d;

  assign px_col     = pixel_x >> GX_W;
  assign px_row     = pixel_y >> GY_W;
  assign in_area    = (px_col < 10'(COLS)) && (px_row < 10'(ROWS));
  assign rd_addr    = in_area ? ADDR_W'(px_row) * ADDR_W'(COLS) + ADDR_W'(px_col) : '0;
  assign hit        = (px_col == 10'(col_q)) && (px_row == 10'(row_q));
  assign frame_tick = p_tick && (pixel_x == 10'd0) && (pixel_y == 10'd0);
  // ~gx_q == CHAR_W-1-gx_q because CHAR_W is a power of two (MSB is leftmost).
  assign pix_on     = font_data[~gx_q] ^ (hit_q & blink_q);
  assign font_addr  = {chr_q, gy_q};
  assign rgb        = rgb_q;

  always_comb begin
    chr_d   = chr_q;
    gy_d    = gy_q;
    gx_d    = gx_q;
    von_d   = von_q;
    area_d  = area_q;
    hit_d   = hit_q;
    rgb_d   = rgb_q;
    frame_d = frame_q;
    blink_d = blink_q;
    if (p_tick) begin
      chr_d  = mem[rd_addr];
      gy_d   = pixel_y[GY_W-1:0];
      gx_d   = pixel_x[GX_W-1:0];
      von_d  = video_on;
      area_d = in_area;
      hit_d  = hit;
      rgb_d  = !von_q ? '0 : (area_q && pix_on) ? FG_COLOR : BG_COLOR;
    end
    if (frame_tick) begin
      if (frame_q == FC_W'(BLINK_FRAMES-1)) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      clr_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      chr_q   <= '0;
      gy_q    <= '0;
      gx_q    <= '0;
      von_q   <= 1'b0;
      area_q  <= 1'b0;
      hit_q   <= 1'b0;
      rgb_q   <= '0;
      frame_q <= '0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      chr_q   <= chr_d;
      gy_q    <= gy_d;
      gx_q    <= gx_d;
      von_q   <= von_d;
      area_q  <= area_d;
      hit_q   <= hit_d;
      rgb_q   <= rgb_d;
      frame_q <= frame_d;
      blink_q <= blink_d;
    end
  end

endmodule

// File: tb/tb_text_console_core.sv
// Directed bench for text_console_core with a behavioural one-clock font ROM.
module tb_text_console_core;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        p_tick = 1'b0;
  logic        video_on = 1'b0;
  logic [9:0]  pixel_x = '0;
  logic [9:0]  pixel_y = '0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = '0;
  logic [6:0]  cmd_data = '0;
  logic        cmd_ready;
  logic [10:0] font_addr;
  logic [7:0]  font_data = '0;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [2:0]  rgb;

  int tests = 0;
  int fails = 0;

  text_console_core #(.BLINK_FRAMES(2)) dut (
    .clk(clk), .reset_n(reset_n), .p_tick(p_tick), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .cmd_valid(cmd_valid),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .font_addr(font_addr), .font_data(font_data),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .rgb(rgb)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] glyph(input logic [6:0] c, input logic [3:0] r);
    logic [7:0] cc;
    logic [7:0] rr;
    cc = {1'b0, c};
    rr = {4'b0, r};
    return (cc * 8'd37) ^ (rr * 8'd11) ^ 8'h5A;
  endfunction

  always @(posedge clk) font_data <= glyph(font_addr[10:4], font_addr[3:0]);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int x, input int y, input logic von);
    @(negedge clk);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
    p_tick   = 1'b1;
    @(negedge clk);
    p_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [6:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("cmd_wait_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic chk_cur(input string tag, input int c, input int r);
    chk({tag, "_col"}, 32'(cursor_col), 32'(c));
    chk({tag, "_row"}, 32'(cursor_row), 32'(r));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    logic [7:0] g;
    logic [2:0] prev_exp;
    logic have_prev;
    logic inv;

    // Reset
    repeat (3) @(negedge clk);
    chk("rst_rgb", 32'(rgb), 32'd0);
    chk("rst_font_addr", 32'(font_addr), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk_cur("rst_cursor", 0, 0);

    for (int i = 0; i < 6; i++) begin
      tick(i * 8, i * 16, 1'b0);
      chk("video_off_rgb", 32'(rgb), 32'd0);
    end

    // CLEAR with WRITE commands held on cmd_valid for the whole sweep
    do_cmd(2'd3, 7'h00);
    chk("clear_ready_low", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_data  = 7'h5A;
    n = 0;
    while (!cmd_ready && n < 3000) begin
      n++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("clear_busy_cycles", 32'(n), 32'd2400);
    chk_cur("clear_cursor", 0, 0);

    bad = 0;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++) begin
        tick(c * 8, r * 16, 1'b0);
        if (font_addr[10:4] !== 7'h20) bad++;
      end
    chk("clear_cells_bad", 32'(bad), 32'd0);

    // WRITE 'A' then scan cell (0,0)
    do_cmd(2'd0, 7'h41);
    chk_cur("write_a_cursor", 1, 0);
    have_prev = 1'b0;
    prev_exp  = '0;
    for (int r = 0; r < 16; r++)
      for (int b = 0; b < 8; b++) begin
        tick(b, r, 1'b1);
        chk("scan_font_addr", 32'(font_addr), 32'({7'h41, 4'(r)}));
        if (have_prev) chk("scan_rgb", 32'(rgb), 32'(prev_exp));
        g = glyph(7'h41, 4'(r));
        prev_exp  = g[7-b] ? 3'b111 : 3'b000;
        have_prev = 1'b1;
      end
    tick(900, 700, 1'b1);
    chk("scan_rgb_last", 32'(rgb), 32'(prev_exp));

    // Cursor wrap cases
    for (int i = 0; i < 29; i++) do_cmd(2'd2, 7'h00);
    chk_cur("nl_to_last_row", 0, 29);
    for (int i = 0; i < 79; i++) do_cmd(2'd0, 7'h2E);
    chk_cur("write_to_last_cell", 79, 29);
    do_cmd(2'd0, 7'h2E);
    chk_cur("write_wrap_last_cell", 0, 0);
    for (int i = 0; i < 5; i++) do_cmd(2'd2, 7'h00);
    do_cmd(2'd1, 7'h00);
    chk_cur("left_wrap_row", 79, 4);
    for (int i = 0; i < 25; i++) do_cmd(2'd2, 7'h00);
    for (int i = 0; i < 12; i++) do_cmd(2'd0, 7'h2E);
    chk_cur("at_12_29", 12, 29);
    do_cmd(2'd2, 7'h00);
    chk_cur("newline_wrap", 0, 0);
    do_cmd(2'd1, 7'h00);
    chk_cur("left_at_origin", 0, 0);

    // p_tick on the same edge as a WRITE to the displayed cell
    @(negedge clk);
    pixel_x   = 10'd0;
    pixel_y   = 10'd0;
    video_on  = 1'b1;
    p_tick    = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_data  = 7'h42;
    @(negedge clk);
    p_tick    = 1'b0;
    cmd_valid = 1'b0;
    chk("collision_old_char", 32'(font_addr[10:4]), 32'h41);
    chk_cur("collision_cursor", 1, 0);
    tick(0, 0, 1'b1);
    chk("collision_new_char", 32'(font_addr[10:4]), 32'h42);

    // reset_n pulsed at CLEAR cycle 1000
    do_cmd(2'd3, 7'h00);
    repeat (1000) @(negedge clk);
    chk("midclear_busy", 32'(cmd_ready), 32'd0);
    reset_n = 1'b0;
    #3;
    chk("midclear_rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("midclear_ready", 32'(cmd_ready), 32'd1);
    chk_cur("midclear_cursor", 0, 0);

    // Blink: cursor at (0,0); cells (0,0) and (1,0) hold spaces from the partial sweep
    g = glyph(7'h20, 4'd2);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick(0, 0, 1'b1);
      tick(3, 2, 1'b1);
      tick(11, 2, 1'b1);
      inv = (k == 2) || (k == 3);
      chk($sformatf("blink_cursor_f%0d", k), 32'(rgb), 32'((g[4] ^ inv) ? 3'b111 : 3'b000));
      tick(800, 600, 1'b1);
      chk($sformatf("blink_other_f%0d", k), 32'(rgb), 32'(g[4] ? 3'b111 : 3'b000));
    end
    tick(800, 600, 1'b1);
    chk("out_of_area_bg", 32'(rgb), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
